// File: rtl/controller_param_pkg.sv
// ----------------------------------------------------------------------------
// controller_param_pkg
// Purpose : Shared definitions for the parametrised accumulator-CPU controller.
//           One-hot state encoding, opcode codes, trap-cause codes and a helper
//           that sizes the memory wait-state counter.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package controller_param_pkg;

    // One-hot state encoding; the value doubles as the STATE output vector.
    typedef enum logic [9:0] {
        S_INIT   = 10'h001,
        S_FETCH  = 10'h002,
        S_LDIR   = 10'h004,
        S_DECODE = 10'h008,
        S_OPRD   = 10'h010,
        S_ALU    = 10'h020,
        S_STOR   = 10'h040,
        S_BRANCH = 10'h080,
        S_HALT   = 10'h100,
        S_TRAP   = 10'h200
    } state_t;

    // Opcode codes; anything above OP_LAST is illegal.
    localparam int OP_NOP   = 0;
    localparam int OP_ADD   = 1;
    localparam int OP_SUB   = 2;
    localparam int OP_STORE = 3;
    localparam int OP_BNZ   = 4;
    localparam int OP_BZ    = 5;
    localparam int OP_JMP   = 6;
    localparam int OP_CLR   = 7;
    localparam int OP_HALT  = 8;
    localparam int OP_LAST  = 8;

    typedef enum logic [1:0] {
        TC_NONE     = 2'd0,
        TC_ILLEGAL  = 2'd1,
        TC_TIMEOUT  = 2'd2,
        TC_OVERFLOW = 2'd3
    } trap_cause_t;

    // Counter width for a wait limit; at least one bit so WAIT_MAX=0 still
    // elaborates (the timeout is disabled in that case).
    function automatic int wait_cnt_w(input int wmax);
        int w;
        w = $clog2(wmax + 1);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/controller_param_wait_timer.sv
// ----------------------------------------------------------------------------
// controller_param_wait_timer
// Purpose : Counts cycles spent waiting for MEM_RDY in a memory-access state
//           and flags a timeout when the limit is reached with no response.
// Ports   : i_clk     clock, rising edge
//           i_rst_n   asynchronous active-low reset
//           i_clr     clear the count (asserted on every state change)
//           i_active  controller is in a memory-access state
//           i_rdy     memory response this cycle
//           o_expired limit reached and still no response this cycle
// ----------------------------------------------------------------------------
module controller_param_wait_timer
    import controller_param_pkg::*;
#(
    parameter int WAIT_MAX = 7
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_active,
    input  logic i_rdy,
    output logic o_expired
);

    localparam int            CW         = wait_cnt_w(WAIT_MAX);
    localparam logic [CW-1:0] LIMIT      = CW'(WAIT_MAX);
    localparam bit            TIMEOUT_EN = (WAIT_MAX != 0);

    logic [CW-1:0] r_count;

    // Holds at the limit; the controller leaves the state on that cycle anyway.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_active && !i_rdy && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // A response arriving on the limit cycle wins over the timeout.
    assign o_expired = TIMEOUT_EN && i_active && !i_rdy && (r_count == LIMIT);

endmodule

// File: rtl/controller_param.sv
// ----------------------------------------------------------------------------
// controller_param
// Purpose : One-hot FSM sequencing fetch/decode/execute for an accumulator CPU,
//           with memory wait-state timeout, branch/clear/halt ops and overflow
//           handling (trap or sticky flag).
// Ports   : CLK, RESET_N (async active-low)
//           OPCODE[OP_W]  IR opcode, sampled in DECODE
//           ZERO          accumulator is zero
//           OVERFLOW      ALU overflow, meaningful in ALU
//           MEM_RDY       memory access complete this cycle
//           RESUME        leave HALT
//           ADDSUB CL CL_AC DORPC LD_AC LD_D LD_IR LD_PC MEM_EN PC_CNT RORW
//                         datapath / memory strobes
//           STATE[10]     one-hot state, HALTED, TRAP, TRAP_CAUSE[2], OVF_FLAG
// ----------------------------------------------------------------------------
module controller_param
    import controller_param_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int WAIT_MAX = 7,
    parameter int OVF_TRAP = 1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [OP_W-1:0] OPCODE,
    input  logic            ZERO,
    input  logic            OVERFLOW,
    input  logic            MEM_RDY,
    input  logic            RESUME,
    output logic            ADDSUB,
    output logic            CL,
    output logic            CL_AC,
    output logic            DORPC,
    output logic            LD_AC,
    output logic            LD_D,
    output logic            LD_IR,
    output logic            LD_PC,
    output logic            MEM_EN,
    output logic            PC_CNT,
    output logic            RORW,
    output logic [9:0]      STATE,
    output logic            HALTED,
    output logic            TRAP,
    output logic [1:0]      TRAP_CAUSE,
    output logic            OVF_FLAG
);

    localparam bit OVF_TRAP_EN = (OVF_TRAP != 0);

    function automatic logic op_is(input logic [OP_W-1:0] v, input int code);
        return v == OP_W'(code);
    endfunction

    state_t          r_state;
    logic [OP_W-1:0] r_op;
    trap_cause_t     r_trap_cause;
    logic            r_ovf_flag;

    state_t          w_next;
    trap_cause_t     w_next_cause;
    logic            w_set_ovf;
    logic            w_in_wait;
    logic            w_timer_clr;
    logic            w_expired;
    logic            w_arith;
    logic            w_ovf_block;
    logic            w_take;

    assign w_in_wait   = (r_state == S_FETCH) || (r_state == S_OPRD) || (r_state == S_STOR);
    // Any state change restarts the count, so each memory state starts from 0.
    assign w_timer_clr = (w_next != r_state);
    assign w_arith     = op_is(r_op, OP_ADD) || op_is(r_op, OP_SUB);
    assign w_ovf_block = OVERFLOW && OVF_TRAP_EN;
    assign w_take      = op_is(r_op, OP_JMP) || (op_is(r_op, OP_BNZ) && !ZERO) ||
                         (op_is(r_op, OP_BZ) && ZERO);

    controller_param_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .i_clk     (CLK),
        .i_rst_n   (RESET_N),
        .i_clr     (w_timer_clr),
        .i_active  (w_in_wait),
        .i_rdy     (MEM_RDY),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next       = r_state;
        w_next_cause = TC_NONE;
        w_set_ovf    = 1'b0;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH: begin
                if (MEM_RDY) begin
                    w_next = S_LDIR;
                end else if (w_expired) begin
                    w_next       = S_TRAP;
                    w_next_cause = TC_TIMEOUT;
                end
            end
            S_LDIR:   w_next = S_DECODE;
            // Decode looks at OPCODE directly; r_op captures it on this edge.
            S_DECODE: begin
                if (OPCODE > OP_W'(OP_LAST)) begin
                    w_next       = S_TRAP;
                    w_next_cause = TC_ILLEGAL;
                end else if (op_is(OPCODE, OP_ADD) || op_is(OPCODE, OP_SUB)) begin
                    w_next = S_OPRD;
                end else if (op_is(OPCODE, OP_CLR)) begin
                    w_next = S_ALU;
                end else if (op_is(OPCODE, OP_STORE)) begin
                    w_next = S_STOR;
                end else if (op_is(OPCODE, OP_BNZ) || op_is(OPCODE, OP_BZ) ||
                             op_is(OPCODE, OP_JMP)) begin
                    w_next = S_BRANCH;
                end else if (op_is(OPCODE, OP_HALT)) begin
                    w_next = S_HALT;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_OPRD: begin
                if (MEM_RDY) begin
                    w_next = S_ALU;
                end else if (w_expired) begin
                    w_next       = S_TRAP;
                    w_next_cause = TC_TIMEOUT;
                end
            end
            // Overflow only matters for arithmetic; CLR never overflows.
            S_ALU: begin
                if (w_arith && OVERFLOW && OVF_TRAP_EN) begin
                    w_next       = S_TRAP;
                    w_next_cause = TC_OVERFLOW;
                end else begin
                    w_next    = S_FETCH;
                    w_set_ovf = w_arith && OVERFLOW;
                end
            end
            S_STOR: begin
                if (MEM_RDY) begin
                    w_next = S_FETCH;
                end else if (w_expired) begin
                    w_next       = S_TRAP;
                    w_next_cause = TC_TIMEOUT;
                end
            end
            S_BRANCH: w_next = S_FETCH;
            S_HALT:   if (RESUME) w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= S_INIT;
            r_trap_cause <= TC_NONE;
            r_ovf_flag   <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((w_next == S_TRAP) && (r_state != S_TRAP)) begin
                r_trap_cause <= w_next_cause;
            end
            if (w_set_ovf) begin
                r_ovf_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (r_state == S_DECODE) begin
            r_op <= OPCODE;
        end
    end

    always_comb begin
        ADDSUB = 1'b0;
        CL     = 1'b0;
        CL_AC  = 1'b0;
        DORPC  = 1'b0;
        LD_AC  = 1'b0;
        LD_D   = 1'b0;
        LD_IR  = 1'b0;
        LD_PC  = 1'b0;
        MEM_EN = 1'b0;
        PC_CNT = 1'b0;
        RORW   = 1'b0;
        case (r_state)
            S_INIT:   CL = 1'b1;
            S_FETCH: begin
                MEM_EN = 1'b1;
                RORW   = 1'b1;
            end
            S_LDIR: begin
                LD_IR  = 1'b1;
                PC_CNT = 1'b1;
            end
            S_OPRD: begin
                MEM_EN = 1'b1;
                RORW   = 1'b1;
                DORPC  = 1'b1;
                LD_D   = MEM_RDY;
            end
            S_ALU: begin
                if (w_arith) begin
                    LD_AC  = !w_ovf_block;
                    ADDSUB = op_is(r_op, OP_SUB);
                end else if (op_is(r_op, OP_CLR)) begin
                    CL_AC = 1'b1;
                end
            end
            S_STOR: begin
                MEM_EN = 1'b1;
                DORPC  = 1'b1;
            end
            S_BRANCH: LD_PC = w_take;
            default: ;
        endcase
    end

    assign STATE      = r_state;
    assign HALTED     = (r_state == S_HALT);
    assign TRAP       = (r_state == S_TRAP);
    assign TRAP_CAUSE = r_trap_cause;
    assign OVF_FLAG   = r_ovf_flag;

endmodule

// File: tb/tb_controller_param.sv
// ----------------------------------------------------------------------------
// tb_controller_param
// Purpose : Self-checking bench for controller_param. Two instances share all
//           inputs: dut traps on overflow, dut0 sets the sticky flag instead.
// ----------------------------------------------------------------------------
module tb_controller_param;

    logic       CLK = 1'b1;
    logic       RESET_N;
    logic [3:0] OPCODE;
    logic       ZERO, OVERFLOW, MEM_RDY, RESUME;

    logic       ADDSUB, CL, CL_AC, DORPC, LD_AC, LD_D, LD_IR, LD_PC, MEM_EN, PC_CNT, RORW;
    logic [9:0] STATE;
    logic       HALTED, TRAP, OVF_FLAG;
    logic [1:0] TRAP_CAUSE;

    logic       ADDSUB_o0, CL_o0, CL_AC_o0, DORPC_o0, LD_AC_o0, LD_D_o0, LD_IR_o0, LD_PC_o0;
    logic       MEM_EN_o0, PC_CNT_o0, RORW_o0;
    logic [9:0] STATE_o0;
    logic       HALTED_o0, TRAP_o0, OVF_FLAG_o0;
    logic [1:0] TRAP_CAUSE_o0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int st;
        bit rdy;
        bit res;
    } step_t;

    always #5 CLK = ~CLK;

    controller_param #(.OP_W(4), .WAIT_MAX(7), .OVF_TRAP(1)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .OPCODE(OPCODE), .ZERO(ZERO), .OVERFLOW(OVERFLOW),
        .MEM_RDY(MEM_RDY), .RESUME(RESUME),
        .ADDSUB(ADDSUB), .CL(CL), .CL_AC(CL_AC), .DORPC(DORPC), .LD_AC(LD_AC), .LD_D(LD_D),
        .LD_IR(LD_IR), .LD_PC(LD_PC), .MEM_EN(MEM_EN), .PC_CNT(PC_CNT), .RORW(RORW),
        .STATE(STATE), .HALTED(HALTED), .TRAP(TRAP), .TRAP_CAUSE(TRAP_CAUSE), .OVF_FLAG(OVF_FLAG)
    );

    controller_param #(.OP_W(4), .WAIT_MAX(7), .OVF_TRAP(0)) dut0 (
        .CLK(CLK), .RESET_N(RESET_N), .OPCODE(OPCODE), .ZERO(ZERO), .OVERFLOW(OVERFLOW),
        .MEM_RDY(MEM_RDY), .RESUME(RESUME),
        .ADDSUB(ADDSUB_o0), .CL(CL_o0), .CL_AC(CL_AC_o0), .DORPC(DORPC_o0), .LD_AC(LD_AC_o0),
        .LD_D(LD_D_o0), .LD_IR(LD_IR_o0), .LD_PC(LD_PC_o0), .MEM_EN(MEM_EN_o0),
        .PC_CNT(PC_CNT_o0), .RORW(RORW_o0), .STATE(STATE_o0), .HALTED(HALTED_o0),
        .TRAP(TRAP_o0), .TRAP_CAUSE(TRAP_CAUSE_o0), .OVF_FLAG(OVF_FLAG_o0)
    );

    // Advance to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        #2;
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [9:0] strobes;
        #85;
        RESET_N = 1'b0;
        #115;
        strobes = {ADDSUB, CL_AC, DORPC, LD_AC, LD_D, LD_IR, LD_PC, MEM_EN, PC_CNT, RORW};
        checks++; if (STATE !== 10'h001) begin errors++; $display("FAIL reset_state: got %h want 001", STATE); end
        checks++; if (CL !== 1'b1) begin errors++; $display("FAIL reset_cl: got %b want 1", CL); end
        checks++; if (strobes !== 10'h000) begin errors++; $display("FAIL reset_strobes: got %h want 000", strobes); end
        checks++; if ({HALTED, TRAP, TRAP_CAUSE, OVF_FLAG} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {HALTED, TRAP, TRAP_CAUSE, OVF_FLAG});
        end
        checks++; if (STATE_o0 !== 10'h001) begin errors++; $display("FAIL reset_state_o0: got %h want 001", STATE_o0); end
        #85;
        RESET_N = 1'b1;
        tick();
        checks++; if (STATE !== 10'h002) begin errors++; $display("FAIL reset_first_edge: got %h want 002", STATE); end
    endtask

    task automatic test_add_sub();
        int seq[5] = '{1, 2, 3, 4, 5};
        MEM_RDY = 1'b1; ZERO = 1'b0; OVERFLOW = 1'b0; RESUME = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            OPCODE = 4'(k);
            for (int i = 0; i < 5; i++) begin
                #1;
                checks++; if (STATE !== (10'd1 << seq[i])) begin
                    errors++; $display("FAIL addsub_state op%0d step%0d: got %h want %h", k, i, STATE, 10'd1 << seq[i]);
                end
                if (seq[i] == 4) begin
                    checks++; if (LD_D !== 1'b1) begin errors++; $display("FAIL addsub_ld_d op%0d: got %b want 1", k, LD_D); end
                end
                if (seq[i] == 5) begin
                    checks++; if (LD_AC !== 1'b1) begin errors++; $display("FAIL addsub_ld_ac op%0d: got %b want 1", k, LD_AC); end
                    checks++; if (ADDSUB !== (k == 2)) begin
                        errors++; $display("FAIL addsub_addsub op%0d: got %b want %b", k, ADDSUB, (k == 2));
                    end
                end
                tick();
            end
        end
        #1;
        checks++; if (STATE !== 10'h002) begin errors++; $display("FAIL addsub_return: got %h want 002", STATE); end
    endtask

    task automatic test_branch();
        int  ops[6] = '{4, 4, 5, 5, 6, 6};
        bit  zs[6]  = '{0, 1, 0, 1, 0, 1};
        bit  exp[6] = '{1, 0, 0, 1, 1, 1};
        int  seq[4] = '{1, 2, 3, 7};
        MEM_RDY = 1'b1;
        for (int c = 0; c < 6; c++) begin
            OPCODE = 4'(ops[c]);
            ZERO   = zs[c];
            for (int i = 0; i < 4; i++) begin
                #1;
                checks++; if (STATE !== (10'd1 << seq[i])) begin
                    errors++; $display("FAIL branch_state case%0d step%0d: got %h want %h", c, i, STATE, 10'd1 << seq[i]);
                end
                if (seq[i] == 7) begin
                    checks++; if (LD_PC !== exp[c]) begin
                        errors++; $display("FAIL branch_ld_pc op%0d z%0d: got %b want %b", ops[c], zs[c], LD_PC, exp[c]);
                    end
                end
                tick();
            end
        end
        #1;
        checks++; if (STATE !== 10'h002) begin errors++; $display("FAIL branch_return: got %h want 002", STATE); end
        ZERO = 1'b0;
    endtask

    task automatic test_store_wait();
        for (int trial = 0; trial < 2; trial++) begin
            int low = (trial == 0) ? 7 : 8;
            OPCODE = 4'd3; MEM_RDY = 1'b1;
            #1;
            checks++; if (STATE !== 10'h002) begin errors++; $display("FAIL store_start t%0d: got %h want 002", trial, STATE); end
            tick(); tick(); tick();
            MEM_RDY = 1'b0;
            for (int i = 0; i < low; i++) begin
                #1;
                checks++; if ({STATE, MEM_EN, RORW, DORPC} !== {10'h040, 3'b101}) begin
                    errors++; $display("FAIL store_wait t%0d cyc%0d: got %h/%b%b%b want 040/101", trial, i, STATE, MEM_EN, RORW, DORPC);
                end
                tick();
            end
            if (trial == 0) begin
                MEM_RDY = 1'b1;
                #1;
                checks++; if (STATE !== 10'h040) begin errors++; $display("FAIL store_late_rdy: got %h want 040", STATE); end
                tick();
                #1;
                checks++; if (STATE !== 10'h002) begin errors++; $display("FAIL store_to_fetch: got %h want 002", STATE); end
            end else begin
                #1;
                checks++; if ({STATE, TRAP, TRAP_CAUSE} !== {10'h200, 1'b1, 2'd2}) begin
                    errors++; $display("FAIL store_timeout: got %h/%b/%0d want 200/1/2", STATE, TRAP, TRAP_CAUSE);
                end
                RESUME = 1'b1;
                tick(); tick();
                #1;
                checks++; if ({STATE, TRAP_CAUSE} !== {10'h200, 2'd2}) begin
                    errors++; $display("FAIL trap_hold: got %h/%0d want 200/2", STATE, TRAP_CAUSE);
                end
                RESUME = 1'b0;
                do_reset();
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        MEM_RDY = 1'b1; OPCODE = 4'd1; OVERFLOW = 1'b0;
        tick(); tick(); tick(); tick();
        OVERFLOW = 1'b1;
        #1;
        checks++; if (STATE !== 10'h020) begin errors++; $display("FAIL ovf_in_alu: got %h want 020", STATE); end
        checks++; if (LD_AC !== 1'b0) begin errors++; $display("FAIL ovf_trap_ld_ac: got %b want 0", LD_AC); end
        checks++; if (LD_AC_o0 !== 1'b1) begin errors++; $display("FAIL ovf_flag_ld_ac: got %b want 1", LD_AC_o0); end
        tick();
        OVERFLOW = 1'b0;
        #1;
        checks++; if ({STATE, TRAP_CAUSE, OVF_FLAG} !== {10'h200, 2'd3, 1'b0}) begin
            errors++; $display("FAIL ovf_trap: got %h/%0d/%b want 200/3/0", STATE, TRAP_CAUSE, OVF_FLAG);
        end
        checks++; if ({STATE_o0, OVF_FLAG_o0, TRAP_CAUSE_o0} !== {10'h002, 1'b1, 2'd0}) begin
            errors++; $display("FAIL ovf_sticky: got %h/%b/%0d want 002/1/0", STATE_o0, OVF_FLAG_o0, TRAP_CAUSE_o0);
        end
        OPCODE = 4'd0;
        tick(); tick(); tick();
        #1;
        checks++; if ({STATE_o0, OVF_FLAG_o0} !== {10'h002, 1'b1}) begin
            errors++; $display("FAIL ovf_flag_held: got %h/%b want 002/1", STATE_o0, OVF_FLAG_o0);
        end
        do_reset();
        #1;
        checks++; if ({OVF_FLAG_o0, TRAP_CAUSE} !== 3'b000) begin
            errors++; $display("FAIL ovf_reset_clear: got %b want 000", {OVF_FLAG_o0, TRAP_CAUSE});
        end
    endtask

    task automatic test_illegal_halt();
        do_reset();
        MEM_RDY = 1'b1; OPCODE = 4'hF; RESUME = 1'b0;
        tick(); tick(); tick();
        #1;
        checks++; if ({STATE, TRAP, TRAP_CAUSE} !== {10'h200, 1'b1, 2'd1}) begin
            errors++; $display("FAIL illegal_trap: got %h/%b/%0d want 200/1/1", STATE, TRAP, TRAP_CAUSE);
        end
        do_reset();
        OPCODE = 4'd8;
        tick(); tick(); tick();
        #1;
        checks++; if ({STATE, HALTED} !== {10'h100, 1'b1}) begin
            errors++; $display("FAIL halt_enter: got %h/%b want 100/1", STATE, HALTED);
        end
        tick(); tick();
        #1;
        checks++; if (STATE !== 10'h100) begin errors++; $display("FAIL halt_hold: got %h want 100", STATE); end
        RESUME = 1'b1;
        tick();
        RESUME = 1'b0;
        #1;
        checks++; if ({STATE, HALTED} !== {10'h002, 1'b0}) begin
            errors++; $display("FAIL halt_resume: got %h/%b want 002/0", STATE, HALTED);
        end
    endtask

    task automatic test_reset_midop();
        MEM_RDY = 1'b1; OPCODE = 4'd1;
        tick(); tick(); tick();
        MEM_RDY = 1'b0;
        #1;
        checks++; if ({STATE, MEM_EN} !== {10'h010, 1'b1}) begin
            errors++; $display("FAIL midop_oprd: got %h/%b want 010/1", STATE, MEM_EN);
        end
        RESET_N = 1'b0;
        #1;
        checks++; if ({STATE, MEM_EN, CL} !== {10'h001, 1'b0, 1'b1}) begin
            errors++; $display("FAIL midop_abort: got %h/%b/%b want 001/0/1", STATE, MEM_EN, CL);
        end
        RESET_N = 1'b1;
        tick();
        #1;
        checks++; if (STATE !== 10'h002) begin errors++; $display("FAIL midop_restart: got %h want 002", STATE); end
    endtask

    // Random instruction stream: the model turns each instruction into the
    // list of states it must visit, with the memory/resume input per cycle.
    task automatic test_random();
        step_t q[$];
        do_reset();
        OVERFLOW = 1'b0; RESUME = 1'b0;
        for (int n = 0; n < 40; n++) begin
            int op = $urandom_range(0, 8);
            bit z  = 1'($urandom_range(0, 1));
            q.delete();
            for (int w = $urandom_range(0, 3); w > 0; w--) q.push_back('{1, 1'b0, 1'b0});
            q.push_back('{1, 1'b1, 1'b0});
            q.push_back('{2, 1'b0, 1'b0});
            q.push_back('{3, 1'b0, 1'b0});
            case (op)
                1, 2: begin
                    for (int w = $urandom_range(0, 3); w > 0; w--) q.push_back('{4, 1'b0, 1'b0});
                    q.push_back('{4, 1'b1, 1'b0});
                    q.push_back('{5, 1'b0, 1'b0});
                end
                3: begin
                    for (int w = $urandom_range(0, 3); w > 0; w--) q.push_back('{6, 1'b0, 1'b0});
                    q.push_back('{6, 1'b1, 1'b0});
                end
                4, 5, 6: q.push_back('{7, 1'b0, 1'b0});
                7: q.push_back('{5, 1'b0, 1'b0});
                8: begin
                    for (int w = $urandom_range(0, 2); w > 0; w--) q.push_back('{8, 1'b0, 1'b0});
                    q.push_back('{8, 1'b0, 1'b1});
                end
                default: ;
            endcase
            OPCODE = 4'(op);
            ZERO   = z;
            foreach (q[i]) begin
                bit exp_mem = (q[i].st == 1) || (q[i].st == 4) || (q[i].st == 6);
                MEM_RDY = q[i].rdy;
                RESUME  = q[i].res;
                #1;
                checks++; if (STATE !== (10'd1 << q[i].st)) begin
                    errors++; $display("FAIL rand_state n%0d op%0d step%0d: got %h want %h", n, op, i, STATE, 10'd1 << q[i].st);
                end
                checks++; if (MEM_EN !== exp_mem) begin
                    errors++; $display("FAIL rand_mem_en n%0d step%0d: got %b want %b", n, i, MEM_EN, exp_mem);
                end
                if (q[i].st == 5) begin
                    checks++; if ({LD_AC, ADDSUB, CL_AC} !== {(op == 1 || op == 2), (op == 2), (op == 7)}) begin
                        errors++; $display("FAIL rand_alu n%0d op%0d: got %b%b%b want %b%b%b", n, op, LD_AC, ADDSUB, CL_AC,
                                           (op == 1 || op == 2), (op == 2), (op == 7));
                    end
                end
                if (q[i].st == 7) begin
                    bit take = (op == 6) || (op == 4 && !z) || (op == 5 && z);
                    checks++; if (LD_PC !== take) begin
                        errors++; $display("FAIL rand_ld_pc n%0d op%0d z%0d: got %b want %b", n, op, z, LD_PC, take);
                    end
                end
                tick();
            end
            RESUME = 1'b0;
        end
        #1;
        checks++; if ({STATE, TRAP_CAUSE} !== {10'h002, 2'd0}) begin
            errors++; $display("FAIL rand_end: got %h/%0d want 002/0", STATE, TRAP_CAUSE);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b1; OPCODE = 4'd0; ZERO = 1'b0; OVERFLOW = 1'b0; MEM_RDY = 1'b0; RESUME = 1'b0;
        test_reset();
        test_add_sub();
        test_branch();
        test_store_wait();
        test_overflow();
        test_illegal_halt();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
